// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the sequential add/subtract controller.
//   state_e          : controller FSM states
//   OpAdd / OpSub    : encoding of the one-bit operation select
//   DefaultWidth/Slice: default datapath and slice widths
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultSlice = 4;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder-subtractor slice.
//   a_i, b_i : operand chunks
//   sub_i    : 1 inverts b_i (the +1 of two's complement arrives via cin_i)
//   cin_i    : carry in
//   sum_o    : sum chunk
//   cout_o   : carry out of the slice MSB
module addsub_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o
);

  logic [SLICE:0] total;

  always_comb begin
    total = {1'b0, a_i} + {1'b0, b_i ^ {SLICE{sub_i}}} + {{SLICE{1'b0}}, cin_i};
  end

  assign sum_o  = total[SLICE-1:0];
  assign cout_o = total[SLICE];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// WIDTH-bit add/subtract computed over WIDTH/SLICE cycles on one shared slice,
// with the carry chained through a register between cycles.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : command handshake; in_op_i selects ADD(0)/SUB(1)
//   in_a_i, in_b_i        : operands, captured on acceptance
//   out_valid_o/out_ready_i: result handshake
//   out_result_o          : a+b or a-b modulo 2^WIDTH
//   out_carry_o           : carry out of MSB (for SUB, 1 = no borrow)
//   out_ovf_o             : signed overflow
//   out_zero_o            : result is zero
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SLICE = DefaultSlice
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_op_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_result_o,
  output logic             out_carry_o,
  output logic             out_ovf_o,
  output logic             out_zero_o
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || SLICE == 0) begin : g_width_check
    $error("WIDTH must be a non-zero integer multiple of SLICE");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, result_q, result_d;
  logic              op_q, carry_q;
  logic [IdxW-1:0]   idx_q;
  logic              in_ready_q, out_valid_q;
  logic              out_carry_q, out_ovf_q, out_zero_q;

  logic [SLICE-1:0]  slice_sum;
  logic              slice_cout;
  logic              ovf_d;

  addsub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i    (a_q[idx_q*SLICE +: SLICE]),
    .b_i    (b_q[idx_q*SLICE +: SLICE]),
    .sub_i  (op_q),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Result with the current chunk merged in; on the last slice this is final.
  always_comb begin
    result_d = result_q;
    result_d[idx_q*SLICE +: SLICE] = slice_sum;
  end

  always_comb begin
    if (op_q == OpAdd) begin
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OpAdd;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i && in_ready_q) begin
            a_q        <= in_a_i;
            b_q        <= in_b_i;
            op_q       <= in_op_i;
            // SUB supplies the two's-complement +1 through the first carry in.
            carry_q    <= (in_op_i == OpSub);
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          result_q <= result_d;
          carry_q  <= slice_cout;
          idx_q    <= idx_q + IdxW'(1);
          if (idx_q == LastIdx) begin
            out_carry_q <= slice_cout;
            out_ovf_q   <= ovf_d;
            out_zero_q  <= ~|result_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Ready rises only after the handshake edge, leaving one idle bubble.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_result_o = result_q;
  assign out_carry_o  = out_carry_q;
  assign out_ovf_o    = out_ovf_q;
  assign out_zero_o   = out_zero_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
module tb_addsub_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_op = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_carry, out_ovf, out_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  addsub_seq_ctrl #(
    .WIDTH (16),
    .SLICE (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_carry_o  (out_carry),
    .out_ovf_o    (out_ovf),
    .out_zero_o   (out_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [W-1:0] r, input logic c, input logic o, input logic z);
    exp_t e;
    e.res = r; e.c = c; e.o = o; e.z = z;
    sb_q.push_back(e);
  endtask

  // Issue one command, check the accept-to-valid latency; returns #1 after the
  // edge where out_valid first rises.
  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic c, input logic o, input logic z);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    push(r, c, o, z);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_op = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 32'd4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("queue_drained", sb_q.size(), 32'd0);
  endtask

  // Monitor: pops one expectation per result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %h, expected no output", out_result);
        end else begin
          e = sb_q.pop_front();
          chk("result", {16'd0, out_result}, {16'd0, e.res});
          chk("carry", {31'd0, out_carry}, {31'd0, e.c});
          chk("ovf", {31'd0, out_ovf}, {31'd0, e.o});
          chk("zero", {31'd0, out_zero}, {31'd0, e.z});
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, out_result}, 32'd0);
    chk("rst_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: op, a, b, result, carry, ovf, zero
    do_op(1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 16'h0003, 16'h000C, 16'hFFF7, 1'b0, 1'b0, 1'b0);
    do_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op(1'b1, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
    do_op(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure: hold out_ready low in DONE while a new command is offered.
    @(negedge clk);
    out_ready = 1'b0;
    do_op(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_op = 1'b0; in_a = 16'h0001; in_b = 16'h0002;
    push(16'h0003, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_result", {16'd0, out_result}, 32'h3333);
      chk("bp_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_bubble_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_bubble_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_accept_late", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    drain();

    // Reset while in RUN at idx=2: op dropped, no output.
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_a = 16'hAAAA; in_b = 16'h5555;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", {16'd0, out_result}, 32'd0);
    chk("mid_rst_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
- Sequencer that computes WIDTH-bit add/subtract by time-multiplexing one SLICE-bit adder-subtractor slice over WIDTH/SLICE cycles, chaining the carry through a register.
- Sits between a requester with a valid/ready command interface and a result consumer with a valid/ready interface.
- Trades latency for area: one narrow adder serves a wide datapath.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be an integer multiple of SLICE; violation is an elaboration-time error.
- SLICE, 4: width of the shared adder-subtractor slice.
- NSLICE, WIDTH/SLICE: derived localparam; number of RUN cycles per operation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  controller can accept a command.
- in_op  in  1  0 = ADD (a+b), 1 = SUB (a-b).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- out_carry  out  1  carry out of MSB. For SUB, 1 means no borrow.
- out_ovf  out  1  two's-complement signed overflow.
- out_zero  out  1  out_result == 0.

Behaviour:
- Reset: state = IDLE. in_ready=1, out_valid=0, out_result=0, out_carry=0, out_ovf=0, out_zero=0. Slice index=0, carry register=0.
- Reset dominates every other event. If rst is asserted in RUN or DONE, the in-flight operation is dropped with no output, and IDLE is reached on the next edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a, in_b and in_op; set carry reg = in_op (SUB injects +1); set idx=0; go to RUN.
- RUN (in_ready=0, out_valid=0):
  - Each cycle, drive the slice with a[idx*SLICE +: SLICE], b chunk, sub=op, cin=carry reg.
  - The slice returns chunk ^ {SLICE{sub}} added with cin.
  - Register the sum chunk into result[idx*SLICE +: SLICE] and the slice cout into the carry reg; increment idx.
  - When idx==NSLICE-1, also compute flags and go to DONE.
- Flags:
  - out_carry = final slice cout.
  - out_ovf (ADD) = (a_msb==b_msb) && (res_msb!=a_msb).
  - out_ovf (SUB) = (a_msb!=b_msb) && (res_msb!=a_msb).
  - out_zero = ~|result.
- DONE:
  - out_valid=1; all outputs held stable while out_ready=0.
  - On out_ready: go to IDLE and drop out_valid.
  - No new command is accepted in the same cycle, so there is one bubble between operations.
- Latency: accept edge at cycle T gives out_valid=1 from cycle T+NSLICE. Throughput is one op per NSLICE+2 cycles with out_ready held high.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Wrap-around: the result is truncated to WIDTH bits; the carry is reported only via out_carry.

Decomposition:
- Package addsub_seq_pkg:
  - state enum: IDLE, RUN, DONE.
  - op encoding: OP_ADD=1'b0, OP_SUB=1'b1.
  - default WIDTH/SLICE constants.
- Sub-module addsub_slice (combinational, parameter SLICE):
  - inputs a, b, sub, cin; outputs sum, cout.
  - Internally inverts b when sub=1; does NOT inject the +1 itself, because the controller supplies it via cin on slice 0 only.
  - Instantiated once inside addsub_seq_ctrl.

Test Plan:
- ADD 0x1234 + 0x0FCD:
  - out_valid exactly 4 cycles after accept.
  - result 0x2201, carry 0, ovf 0, zero 0.
- SUB 0x0003 - 0x000C:
  - result 0xFFF7, carry 0 (borrow), ovf 0, zero 0.
- Signed overflow:
  - ADD 0x7FFF + 0x0001 gives 0x8000, carry 0, ovf 1.
  - SUB 0x8000 - 0x0001 gives 0x7FFF, carry 1, ovf 1.
- SUB 0x5A5A - 0x5A5A, then ADD 0xFFFF + 0x0001:
  - SUB gives 0x0000, zero 1, carry 1, ovf 0.
  - ADD gives 0x0000, zero 1, carry 1, ovf 0 (wrap).
- Backpressure:
  - Setup: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven.
  - out_valid and outputs stay stable throughout; in_ready stays 0; the new command is not accepted until 1 cycle after the out_ready handshake.
- Reset mid-RUN:
  - Assert rst for one cycle at RUN idx=2.
  - Next cycle: IDLE, in_ready=1, out_valid=0, outputs 0.
  - A following ADD 0x0001 + 0x0001 returns 0x0002 with no residue from the aborted op.
